// File: rtl/ex2_pkg.sv
// Shared types for the ex2 transmit side: serialiser states and the operand triple.
package ex2_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SENT_A,
    ST_SENT_B,
    ST_SENT_C,
    ST_GAP
  } tx_state_t;

  typedef struct packed {
    logic [W_DEFAULT-1:0] a;
    logic [W_DEFAULT-1:0] b;
    logic [W_DEFAULT-1:0] c;
  } triple_t;

endpackage

// File: rtl/ex2_fifo.sv
// Synchronous FIFO holding packed operand triples; extra pointer bit separates full from empty.
module ex2_fifo #(
  parameter int DW    = 96,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_chk
    $error("ex2_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ex2_tx.sv
// Serialises buffered (a,b,c) triples as three valid words plus idle gap,
// and predicts the receiver's a*b+c result pulse for scoreboarding.
//
// state      | meaning
// ST_IDLE    | nothing in flight; pops and emits a when the FIFO has data
// ST_SENT_A  | a is on tx_data; b goes out next
// ST_SENT_B  | b is on tx_data; c goes out next
// ST_SENT_C  | c is on tx_data; next edge drops valid and pulses exp_valid
// ST_GAP     | forced idle; at count 0 acts exactly like ST_IDLE
module ex2_tx
  import ex2_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic         tx_valid,
  output logic [W-1:0] tx_data,
  output logic         exp_valid,
  output logic [W-1:0] exp_data,
  output logic [15:0]  sent_cnt,
  output logic         busy
);

  if (GAP < 1) begin : g_gap_chk
    $error("ex2_tx: GAP must be >= 1");
  end

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = 1;

  tx_state_t       state, state_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [W-1:0]    hold_a, hold_b, hold_c;
  logic [W-1:0]    hold_a_n, hold_b_n, hold_c_n;
  logic            tx_valid_n, exp_valid_n;
  logic [W-1:0]    tx_data_n, exp_data_n;
  logic [15:0]     sent_n;
  logic            full, empty, pop;
  logic [3*W-1:0]  fifo_dout;
  logic [W-1:0]    head_a, head_b, head_c;
  logic [W-1:0]    mac;
  logic            can_start;

  ex2_fifo #(.DW(3*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   ({in_a, in_b, in_c}),
    .full  (full),
    .empty (empty),
    .dout  (fifo_dout)
  );

  assign {head_a, head_b, head_c} = fifo_dout;
  assign in_ready  = !full;
  assign mac       = hold_a * hold_b + hold_c;
  assign can_start = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == '0));
  assign busy      = !empty || !can_start;

  always_comb begin
    state_n     = state;
    gap_n       = gap_cnt;
    hold_a_n    = hold_a;
    hold_b_n    = hold_b;
    hold_c_n    = hold_c;
    tx_valid_n  = tx_valid;
    tx_data_n   = tx_data;
    exp_valid_n = 1'b0;
    exp_data_n  = exp_data;
    sent_n      = sent_cnt;
    pop         = 1'b0;
    if (can_start) begin
      if (!empty) begin
        pop        = 1'b1;
        hold_a_n   = head_a;
        hold_b_n   = head_b;
        hold_c_n   = head_c;
        tx_valid_n = 1'b1;
        tx_data_n  = head_a;
        state_n    = ST_SENT_A;
      end else begin
        tx_valid_n = 1'b0;
        tx_data_n  = '0;
        state_n    = ST_IDLE;
      end
    end else begin
      case (state)
        ST_SENT_A: begin
          tx_data_n = hold_b;
          state_n   = ST_SENT_B;
        end
        ST_SENT_B: begin
          tx_data_n = hold_c;
          state_n   = ST_SENT_C;
        end
        ST_SENT_C: begin
          tx_valid_n  = 1'b0;
          tx_data_n   = '0;
          exp_valid_n = 1'b1;
          exp_data_n  = mac;
          sent_n      = sent_cnt + 16'd1;
          gap_n       = GAP_LOAD;
          state_n     = ST_GAP;
        end
        ST_GAP: gap_n = gap_cnt - GAP_ONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      hold_c    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
      sent_cnt  <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      hold_a    <= hold_a_n;
      hold_b    <= hold_b_n;
      hold_c    <= hold_c_n;
      tx_valid  <= tx_valid_n;
      tx_data   <= tx_data_n;
      exp_valid <= exp_valid_n;
      exp_data  <= exp_data_n;
      sent_cnt  <= sent_n;
    end
  end

endmodule

// File: tb/tb_ex2_tx.sv
// Directed bench for ex2_tx: two instances (GAP=1 and GAP=3) share the same stimulus.
module tb_ex2_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a, in_b, in_c;

  logic        in_ready1, tx_valid1, exp_valid1, busy1;
  logic [31:0] tx_data1, exp_data1;
  logic [15:0] sent_cnt1;
  logic        in_ready3, tx_valid3, exp_valid3, busy3;
  logic [31:0] tx_data3, exp_data3;
  logic [15:0] sent_cnt3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned w1_dat[$], w1_cyc[$], w3_dat[$], w3_cyc[$], e1[$], e3[$];

  always #5 clk = ~clk;

  ex2_tx #(.W(32), .DEPTH(4), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .exp_valid(exp_valid1),
    .exp_data(exp_data1), .sent_cnt(sent_cnt1), .busy(busy1));

  ex2_tx #(.W(32), .DEPTH(4), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .tx_valid(tx_valid3), .tx_data(tx_data3), .exp_valid(exp_valid3),
    .exp_data(exp_data3), .sent_cnt(sent_cnt3), .busy(busy3));

  // Stream monitor: records every valid word / expected pulse with its cycle number.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (tx_valid1) begin w1_dat.push_back(tx_data1); w1_cyc.push_back(cyc); end
    if (tx_valid3) begin w3_dat.push_back(tx_data3); w3_cyc.push_back(cyc); end
    if (exp_valid1) e1.push_back(exp_data1);
    if (exp_valid3) e3.push_back(exp_data3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    offer(a, b, c);
    in_valid = 1'b0;
  endtask

  task automatic clear_mon();
    w1_dat.delete(); w1_cyc.delete(); w3_dat.delete(); w3_cyc.delete();
    e1.delete(); e3.delete();
  endtask

  // Checks a captured stream against expected words and the 3-on/GAP-off cadence.
  task automatic chk_stream(input string nm, input int unsigned dat[$], input int unsigned cy[$],
                            input int unsigned exp_w[$], input int gap);
    chk({nm, "_n"}, dat.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < dat.size(); i++) begin
      chk($sformatf("%s_w%0d", nm, i), dat[i], exp_w[i]);
      chk($sformatf("%s_c%0d", nm, i), cy[i] - cy[0], (i / 3) * (3 + gap) + (i % 3));
    end
  endtask

  typedef struct { logic [31:0] a, b, c, r; } vec_t;
  vec_t vt[5];
  int unsigned exp_w[$];
  int unsigned exp_e[$];
  logic rdy1_exp[6];
  logic rdy3_exp[6];

  initial begin
    vt[0] = '{32'd3, 32'd4, 32'd5, 32'd17};
    vt[1] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001};
    vt[2] = '{32'h0001_0000, 32'h0001_0000, 32'd5, 32'd5};
    vt[3] = '{32'h0000_1234, 32'd0, 32'h0000_ABCD, 32'h0000_ABCD};
    vt[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0001_FFFE, 32'hFFFF_FFFF};
    rdy1_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rdy3_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    step(2);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_tx_valid", tx_valid1, 0);
    chk("rst_tx_data", tx_data1, 0);
    chk("rst_exp_valid", exp_valid1, 0);
    chk("rst_exp_data", exp_data1, 0);
    chk("rst_sent", sent_cnt1, 0);
    chk("rst_busy", busy1, 0);
    rst = 1'b0;
    step(2);

    // Single triples into an idle block: exact latency of words and result pulse.
    for (int i = 0; i < 5; i++) begin
      push(vt[i].a, vt[i].b, vt[i].c);
      step(1);
      chk($sformatf("v%0d_va", i), tx_valid1, 1);
      chk($sformatf("v%0d_a", i), tx_data1, vt[i].a);
      chk($sformatf("v%0d_a3", i), tx_data3, vt[i].a);
      step(1);
      chk($sformatf("v%0d_b", i), tx_data1, vt[i].b);
      step(1);
      chk($sformatf("v%0d_c", i), tx_data1, vt[i].c);
      chk($sformatf("v%0d_c3", i), tx_data3, vt[i].c);
      step(1);
      chk($sformatf("v%0d_vdrop", i), tx_valid1, 0);
      chk($sformatf("v%0d_ev", i), exp_valid1, 1);
      chk($sformatf("v%0d_ed", i), exp_data1, vt[i].r);
      chk($sformatf("v%0d_ed3", i), exp_data3, vt[i].r);
      chk($sformatf("v%0d_busy1", i), busy1, 0);
      chk($sformatf("v%0d_busy3", i), busy3, 1);
      step(1);
      chk($sformatf("v%0d_evoff", i), exp_valid1, 0);
      chk($sformatf("v%0d_busy3b", i), busy3, 1);
      step(1);
      chk($sformatf("v%0d_busy3c", i), busy3, 0);
      chk($sformatf("v%0d_sent", i), sent_cnt1, i + 1);
      chk($sformatf("v%0d_sent3", i), sent_cnt3, i + 1);
      step(2);
    end

    // Back-to-back triples: one idle (GAP=1) or three idles (GAP=3) between triples.
    clear_mon();
    offer(2, 3, 1);
    offer(5, 5, 0);
    offer(1, 1, 1);
    in_valid = 1'b0;
    step(30);
    exp_w = '{2, 3, 1, 5, 5, 0, 1, 1, 1};
    exp_e = '{7, 25, 2};
    chk_stream("b2b1", w1_dat, w1_cyc, exp_w, 1);
    chk_stream("b2b3", w3_dat, w3_cyc, exp_w, 3);
    chk("b2b_e1n", e1.size(), 3);
    chk("b2b_e3n", e3.size(), 3);
    for (int i = 0; i < 3 && i < e1.size(); i++) chk($sformatf("b2b_e1_%0d", i), e1[i], exp_e[i]);
    for (int i = 0; i < 3 && i < e3.size(); i++) chk($sformatf("b2b_e3_%0d", i), e3[i], exp_e[i]);
    chk("b2b_sent1", sent_cnt1, 8);
    chk("b2b_sent3", sent_cnt3, 8);

    // Continuous offers: FIFO fills; a full FIFO refuses even when a pop happens.
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      offer(i + 1, 2, i);
      chk($sformatf("ovf_rdy1_%0d", i), in_ready1, rdy1_exp[i]);
      chk($sformatf("ovf_rdy3_%0d", i), in_ready3, rdy3_exp[i]);
    end
    in_valid = 1'b0;
    step(40);
    chk("ovf_w1n", w1_dat.size(), 15);
    chk("ovf_w3n", w3_dat.size(), 15);
    chk("ovf_e1n", e1.size(), 5);
    chk("ovf_e3n", e3.size(), 5);
    for (int i = 0; i < 5 && i < e1.size(); i++) chk($sformatf("ovf_e1_%0d", i), e1[i], 3 * i + 2);
    for (int i = 0; i < 5 && i < e3.size(); i++) chk($sformatf("ovf_e3_%0d", i), e3[i], 3 * i + 2);
    chk("ovf_sent1", sent_cnt1, 13);
    chk("ovf_sent3", sent_cnt3, 13);

    // Reset while b of (7,8,9) is on the wire with two triples queued.
    offer(7, 8, 9);
    offer(1, 2, 3);
    offer(4, 5, 6);
    in_valid = 1'b0;
    chk("mid_b", tx_data1, 8);
    rst = 1'b1;
    #1;
    chk("mid_tx_valid1", tx_valid1, 0);
    chk("mid_tx_valid3", tx_valid3, 0);
    chk("mid_tx_data", tx_data1, 0);
    chk("mid_exp_valid", exp_valid1, 0);
    chk("mid_in_ready", in_ready1, 1);
    chk("mid_busy1", busy1, 0);
    chk("mid_busy3", busy3, 0);
    chk("mid_sent1", sent_cnt1, 0);
    chk("mid_sent3", sent_cnt3, 0);
    step(2);
    rst = 1'b0;
    clear_mon();
    step(20);
    chk("post_rst_w1", w1_dat.size(), 0);
    chk("post_rst_w3", w3_dat.size(), 0);
    chk("post_rst_e1", e1.size(), 0);
    chk("post_rst_e3", e3.size(), 0);

    // Counter wrap from 0xFFFF.
    force dut1.sent_cnt = 16'hFFFF;
    step(1);
    release dut1.sent_cnt;
    step(1);
    chk("wrap_pre", sent_cnt1, 16'hFFFF);
    push(1, 1, 1);
    step(6);
    chk("wrap_sent", sent_cnt1, 0);
    chk("wrap_ed", exp_data1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex2_tx.md
Name: ex2_tx

Overview:
- Transmit-side companion to the three-word multiply-accumulate receiver (result = a*b+c over three consecutive valid words).
- Accepts operand triples (a,b,c) over a ready/valid handshake and buffers them in a small FIFO.
- Serialises each triple onto a validi/data_in-style stream as three back-to-back valid words, then forces idle gap cycles so the receiver returns to its first state.
- Emits a one-cycle expected-result pulse aligned to the receiver's valido, for scoreboarding.

Parameters:
W, 32, data width of each operand and of the stream word.
DEPTH, 4, FIFO capacity in triples (power of two, >= 2).
GAP, 1, idle cycles forced after each triple (>= 1; 0 is illegal and is rejected by an elaboration assertion).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  a triple is offered on in_a/in_b/in_c.
in_ready  output  1  FIFO can accept a triple; equals !full.
in_a  input  W  first operand (multiplicand).
in_b  input  W  second operand (multiplier).
in_c  input  W  third operand (addend).
tx_valid  output  1  stream word valid; drives receiver validi.
tx_data  output  W  stream word; drives receiver data_in.
exp_valid  output  1  one-cycle pulse; expected receiver valido.
exp_data  output  W  expected receiver data_out, (a*b+c) truncated to W bits.
sent_cnt  output  16  count of fully transmitted triples; wraps 0xFFFF -> 0.
busy  output  1  high when the FIFO is non-empty or state != IDLE.

Behaviour:
- Reset (async, any time):
  - tx_valid=0, tx_data=0, exp_valid=0, exp_data=0, sent_cnt=0.
  - FIFO emptied; state=IDLE; gap counter=0.
  - Any in-flight triple is dropped with no partial continuation.
  - in_ready=1 after reset.
- Accept: a push occurs on a posedge where in_valid && in_ready.
  - in_ready depends only on full, never on a same-cycle pop.
  - A full FIFO therefore refuses a push even when a pop happens in the same cycle.
- All outputs are registered. The FSM is IDLE -> SENT_A -> SENT_B -> SENT_C -> GAP -> (IDLE or SENT_A).
- IDLE:
  - FIFO empty: tx_valid=0, tx_data=0.
  - FIFO non-empty: pop into hold registers; tx_valid<=1, tx_data<=a; go to SENT_A.
- SENT_A: tx_data<=b, tx_valid stays 1; go to SENT_B.
- SENT_B: tx_data<=c; go to SENT_C.
- SENT_C:
  - tx_valid<=0, tx_data<=0.
  - exp_valid<=1, exp_data<=lower W bits of (a*b + c), unsigned.
  - sent_cnt increments.
  - gap counter<=GAP-1; go to GAP.
- GAP:
  - exp_valid<=0; tx_valid remains 0.
  - If gap counter != 0: decrement.
  - If gap counter == 0: behave exactly as IDLE in the same cycle (pop and emit a, or go to IDLE).
- Timing:
  - A triple pushed into an empty, idle block at edge k puts word a on tx_data after edge k+1, b after k+2, c after k+3.
  - exp_valid is high for exactly the cycle after edge k+4, matching the receiver's valido.
- Throughput: one triple per 3+GAP cycles. tx_valid is never high for more than 3 consecutive cycles.
- Words are emitted in FIFO order: a, b, c within a triple, triples in push order.
- busy falls to 0 only when the FIFO is empty and the state is IDLE (or GAP with counter 0 and the FIFO empty).
- Push into the FIFO during SENT_x/GAP is independent of the serialiser. Simultaneous push and pop on a non-full FIFO leaves the occupancy unchanged.

Decomposition:
- Package ex2_pkg:
  - W default constant.
  - tx_state_t enum {IDLE, SENT_A, SENT_B, SENT_C, GAP}.
  - packed struct triple_t {a, b, c}.
- Sub-module ex2_fifo:
  - Synchronous FIFO of triple_t, parameter DEPTH.
  - Ports: push/pop/full/empty/din/dout.
  - Pointer width log2(DEPTH)+1 for full/empty disambiguation.
  - Async active-high rst.
- ex2_tx holds the FSM, hold registers, gap counter, exp computation and sent_cnt.

Test Plan:
- Single triple: push (3,4,5) into idle block -> tx_data 3,4,5 on 3 consecutive cycles with tx_valid=1, then tx_valid=0; exp_valid one cycle with exp_data=17; sent_cnt=1.
- Back-to-back, GAP=1: push (2,3,1),(5,5,0),(1,1,1) on consecutive cycles -> stream 2,3,1,-,5,5,0,-,1,1,1 with exactly one idle between triples; exp_data 7, 25, 2; sent_cnt=3.
- Overflow: push (0xFFFF_FFFF,2,3) -> exp_data=0x0000_0001 (truncated). Fill DEPTH=4 with no drain -> in_ready=0 after the 4th push (the 5th offer is refused and never transmitted).
- Reset mid-triple: assert rst while tx_data shows b of (7,8,9) with 2 triples queued -> immediately tx_valid=0, exp_valid=0, in_ready=1, busy=0, sent_cnt=0; no further words after rst deasserts.
- Connected to the receiver: 10 random triples with GAP=1 and GAP=3 -> the receiver's valido/data_out equals exp_valid/exp_data on every cycle; no spurious valido.
- Wrap: preload a sent_cnt of 0xFFFF via 65535 triples (or a force) and send one more -> sent_cnt=0.
